// File: rtl/ex_stage_mc_pkg.sv
// ex_pkg: shared ALU-op, funct, forwarding-select codes and multiplier FSM state for the EX stage.
//   No ports; imported by ex_stage_mc_if, ex_mul_seq and ex_stage_mc.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_SLT = 3'b100;
    localparam logic [2:0] F_SLL = 3'b101;
    localparam logic [2:0] F_MUL = 3'b110;
    localparam logic [2:0] F_SRL = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {IDLE, MUL_BUSY} mulState_t;

endpackage

// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: ID/EX -> EX -> EX/MEM bundle for the execute stage.
//   master: ID/EX side and forwarding unit (drives instruction, forwarding and mem_stall; sees stall/EX-MEM outputs)
//   slave : execute stage (reads instruction fields; drives stall_out, valid_out and EX/MEM register)
interface ex_stage_mc_if #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 3
);

    logic                  valid_in;
    logic [WIDTH-1:0]      pc4;
    logic [WIDTH-1:0]      data1;
    logic [WIDTH-1:0]      data2;
    logic [WIDTH-1:0]      imm;
    logic [REG_ADDR_W-1:0] reg2;
    logic [REG_ADDR_W-1:0] reg3;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  reg_dest;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [WIDTH-1:0]      result_mem;
    logic [WIDTH-1:0]      result_wb;
    logic                  mem_stall;
    logic                  stall_out;
    logic                  valid_out;
    logic [WIDTH-1:0]      alu_result;
    logic                  zero;
    logic [WIDTH-1:0]      branch_target;
    logic [WIDTH-1:0]      store_data;
    logic [REG_ADDR_W-1:0] rd_out;

    modport master (
        output valid_in, pc4, data1, data2, imm, reg2, reg3, alu_src, alu_op, reg_dest,
               fwd_a, fwd_b, result_mem, result_wb, mem_stall,
        input  stall_out, valid_out, alu_result, zero, branch_target, store_data, rd_out
    );

    modport slave (
        input  valid_in, pc4, data1, data2, imm, reg2, reg3, alu_src, alu_op, reg_dest,
               fwd_a, fwd_b, result_mem, result_wb, mem_stall,
        output stall_out, valid_out, alu_result, zero, branch_target, store_data, rd_out
    );

endinterface

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: sequential shift-add multiplier, one partial product per enabled cycle, WIDTH steps, low WIDTH bits kept.
//   clock, reset (sync, active-low), en (step/accept only when high), start (load a, b),
//   a, b (operands), busy (MUL_BUSY), done (final step happens this edge), product (result after this edge's step).
//   Only instantiated when EX_MUL_EN is defined.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    mulState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             last;

    assign busy = state == MUL_BUSY;
    assign last = cnt == CNT_W'(WIDTH - 1);
    assign done = busy & en & last;
    // Accumulator value after the current step, so the final edge can hand it straight to EX/MEM.
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (en) begin
            if (state == IDLE && start) begin
                state  <= MUL_BUSY;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
            end else if (busy) begin
                acc    <= product;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: parametrised execute stage with forwarding muxes, ALU, registered EX/MEM slot and valid/stall handshake.
//   clock, reset (sync, active-low), bus (ex_stage_mc_if.slave: instruction fields, forwarding, mem_stall in;
//   stall_out, valid_out, alu_result, zero, branch_target, store_data, rd_out out).
//   Define EX_MUL_EN to add the multi-cycle multiplier for R-type funct 110; otherwise funct 110 is a one-cycle add.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 3,
    parameter int FUNCT_W    = 3
) (
    input logic          clock,
    input logic          reset,
    ex_stage_mc_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0]      opA;
    logic [WIDTH-1:0]      fwdB;
    logic [WIDTH-1:0]      opB;
    logic [WIDTH-1:0]      aluOut;
    logic [WIDTH-1:0]      target;
    logic [REG_ADDR_W-1:0] rdSel;
    logic [FUNCT_W-1:0]    funct;
    logic                  accept;
    logic                  isMul;
    logic                  mulBusy;
    logic                  mulDone;
    logic [WIDTH-1:0]      product;
    logic [WIDTH-1:0]      mulTarget;
    logic [WIDTH-1:0]      mulStore;
    logic [REG_ADDR_W-1:0] mulRd;

    assign funct         = bus.imm[FUNCT_W-1:0];
    assign opA           = bus.fwd_a == FWD_WB ? bus.result_wb : bus.fwd_a == FWD_MEM ? bus.result_mem : bus.data1;
    assign fwdB          = bus.fwd_b == FWD_WB ? bus.result_wb : bus.fwd_b == FWD_MEM ? bus.result_mem : bus.data2;
    assign opB           = bus.alu_src ? bus.imm : fwdB;
    assign target        = bus.pc4 + (bus.imm << 1);
    assign rdSel         = bus.reg_dest ? bus.reg3 : bus.reg2;
    assign bus.stall_out = bus.mem_stall | mulBusy;
    assign accept        = bus.valid_in & ~bus.stall_out;

    // Reserved alu_op and funct 110 fall through to add; with EX_MUL_EN funct 110 never reaches this result.
    always_comb begin
        aluOut = opA + opB;
        if (bus.alu_op == ALUOP_SUB) aluOut = opA - opB;
        else if (bus.alu_op == ALUOP_RTYPE)
            case (3'(funct))
                F_SUB:   aluOut = opA - opB;
                F_AND:   aluOut = opA & opB;
                F_OR:    aluOut = opA | opB;
                F_SLT:   aluOut = WIDTH'($signed(opA) < $signed(opB));
                F_SLL:   aluOut = opA << opB[SH_W-1:0];
                F_SRL:   aluOut = opA >> opB[SH_W-1:0];
                default: aluOut = opA + opB;
            endcase
    end

`ifdef EX_MUL_EN
    assign isMul = bus.alu_op == ALUOP_RTYPE && 3'(funct) == F_MUL;

    ex_mul_seq #(.WIDTH(WIDTH)) mul (
        .clock   (clock),
        .reset   (reset),
        .en      (~bus.mem_stall),
        .start   (accept & isMul),
        .a       (opA),
        .b       (opB),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (product)
    );
`else
    assign isMul   = 1'b0;
    assign mulBusy = 1'b0;
    assign mulDone = 1'b0;
    assign product = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.valid_out     <= 1'b0;
            bus.alu_result    <= '0;
            bus.zero          <= 1'b0;
            bus.branch_target <= '0;
            bus.store_data    <= '0;
            bus.rd_out        <= '0;
            mulTarget         <= '0;
            mulStore          <= '0;
            mulRd             <= '0;
        end else if (!bus.mem_stall) begin
            if (mulDone) begin
                bus.valid_out     <= 1'b1;
                bus.alu_result    <= product;
                bus.zero          <= product == '0;
                bus.branch_target <= mulTarget;
                bus.store_data    <= mulStore;
                bus.rd_out        <= mulRd;
            end else if (accept && isMul) begin
                // Side results are parked until the product is ready.
                bus.valid_out <= 1'b0;
                mulTarget     <= target;
                mulStore      <= fwdB;
                mulRd         <= rdSel;
            end else if (accept) begin
                bus.valid_out     <= 1'b1;
                bus.alu_result    <= aluOut;
                bus.zero          <= aluOut == '0;
                bus.branch_target <= target;
                bus.store_data    <= fwdB;
                bus.rd_out        <= rdSel;
            end else begin
                bus.valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed vectors pushed into a scoreboard queue; a negedge monitor pops on every EX/MEM transfer.
module tb_ex_stage_mc;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic [15:0] bt;
        logic [15:0] sd;
        logic [2:0]  rd;
    } exp_t;

    logic clock;
    logic reset;
    int   nCmp;
    int   nErr;
    exp_t expQ[$];
    exp_t mon;

    ex_stage_mc_if #(.WIDTH(16), .REG_ADDR_W(3)) bus ();

    ex_stage_mc #(.WIDTH(16), .REG_ADDR_W(3), .FUNCT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && bus.valid_out && !bus.mem_stall) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL spurious valid_out: got result %0h with nothing expected", bus.alu_result);
            end else begin
                mon = expQ.pop_front();
                check("alu_result", bus.alu_result, mon.res);
                check("zero", bus.zero, mon.z);
                check("branch_target", bus.branch_target, mon.bt);
                check("store_data", bus.store_data, mon.sd);
                check("rd_out", bus.rd_out, mon.rd);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] im, input logic [15:0] pc, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] rm,
                         input logic [15:0] rw, input logic rdst, input logic [2:0] r2,
                         input logic [2:0] r3, input logic [15:0] eRes, input logic [15:0] eSd,
                         input logic [15:0] eBt, input logic [2:0] eRd, input bit push);
        bit ok;
        int n;
        bus.alu_op = op; bus.data1 = d1; bus.data2 = d2; bus.imm = im; bus.pc4 = pc;
        bus.alu_src = src; bus.fwd_a = fa; bus.fwd_b = fb; bus.result_mem = rm; bus.result_wb = rw;
        bus.reg_dest = rdst; bus.reg2 = r2; bus.reg3 = r3; bus.valid_in = 1'b1;
        if (push) expQ.push_back('{eRes, eRes == 16'h0, eBt, eSd, eRd});
        n = 0;
        do begin
            ok = !bus.stall_out;
            @(posedge clock); #1;
            n++;
        end while (!ok && n < 100);
        bus.valid_in = 1'b0;
        if (!ok) begin
            nCmp++;
            nErr++;
            $display("FAIL accept timeout: got no accept, expected one within 100 cycles");
        end
    endtask

    // Counts cycles with stall_out high after a multiply accept; optionally holds mem_stall for 3 cycles.
    task automatic mulRun(input int expCycles, input int stallAt);
        int n;
        bit sawValid;
        n = 0;
        sawValid = 0;
        while (bus.stall_out && n < 60) begin
            if (n == stallAt) bus.mem_stall = 1'b1;
            if (n == stallAt + 3) bus.mem_stall = 1'b0;
            if (bus.valid_out) sawValid = 1;
            @(posedge clock); #1;
            n++;
        end
        check("mul stall cycles", n, expCycles);
        check("valid_out low during mul", sawValid, 0);
        check("valid_out after mul", bus.valid_out, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nCmp = 0;
        nErr = 0;
        reset = 1'b0;
        bus.valid_in = 0; bus.pc4 = 0; bus.data1 = 0; bus.data2 = 0; bus.imm = 0; bus.reg2 = 0;
        bus.reg3 = 0; bus.alu_src = 0; bus.alu_op = 0; bus.reg_dest = 0; bus.fwd_a = 0; bus.fwd_b = 0;
        bus.result_mem = 0; bus.result_wb = 0; bus.mem_stall = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
`ifdef EX_MUL_EN
        issue(2'b10, 16'd3, 16'd5, 16'h0006, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 1, 3'd0, 3'd6, 0, 0, 0, 0, 0);
        repeat (5) begin @(posedge clock); #1; end
`endif
        reset = 1'b0;
        @(posedge clock); #1;
        check("reset valid_out", bus.valid_out, 0);
        check("reset alu_result", bus.alu_result, 0);
        check("reset zero", bus.zero, 0);
        check("reset branch_target", bus.branch_target, 0);
        check("reset store_data", bus.store_data, 0);
        check("reset rd_out", bus.rd_out, 0);
        check("reset stall_out", bus.stall_out, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        //     op     d1        d2        imm       pc4       src fa     fb     rm      rw      rdst r2    r3    eRes      eSd       eBt       eRd  push
        issue(2'b00, 16'h1234, 16'h0011, 16'h0004, 16'h0100, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 3'd2, 3'd5, 16'h1245, 16'h0011, 16'h0108, 3'd5, 1);
        check("post-reset latency", bus.valid_out, 1);
        issue(2'b10, 16'd5, 16'd5, 16'h0001, 16'h0010, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd3, 3'd6, 16'h0000, 16'h0005, 16'h0012, 3'd3, 1);
        check("sub latency", bus.valid_out, 1);
        issue(2'b01, 16'h0100, 16'h0001, 16'h0020, 16'h0055, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd1, 3'd6, 16'h00FF, 16'h0001, 16'h0095, 3'd1, 1);
        issue(2'b01, 16'h0003, 16'h0009, 16'hFFFE, 16'h0055, 1, 2'b00, 2'b00, 16'h0, 16'h0, 1, 3'd1, 3'd7, 16'h0005, 16'h0009, 16'h0051, 3'd7, 1);
        issue(2'b00, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 0, 2'b10, 2'b01, 16'd7, 16'd3, 0, 3'd4, 3'd6, 16'h000A, 16'h0003, 16'h0000, 3'd4, 1);
        issue(2'b10, 16'h0F0F, 16'h00FF, 16'h0002, 16'h0002, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h000F, 16'h00FF, 16'h0006, 3'd2, 1);
        issue(2'b10, 16'h0F00, 16'h00F0, 16'h0003, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h0FF0, 16'h00F0, 16'h0006, 3'd2, 1);
        issue(2'b10, 16'hFFFF, 16'h0001, 16'h0004, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h0001, 16'h0001, 16'h0008, 3'd2, 1);
        issue(2'b10, 16'h0001, 16'hFFFF, 16'h0004, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h0000, 16'hFFFF, 16'h0008, 3'd2, 1);
        issue(2'b10, 16'h0003, 16'h0014, 16'h0005, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h0030, 16'h0014, 16'h000A, 3'd2, 1);
        issue(2'b10, 16'h8000, 16'h0003, 16'h0007, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h1000, 16'h0003, 16'h000E, 3'd2, 1);
        issue(2'b11, 16'h0002, 16'h0003, 16'h0000, 16'h0030, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd2, 3'd6, 16'h0005, 16'h0003, 16'h0030, 3'd2, 1);
        issue(2'b00, 16'h0004, 16'h0001, 16'h0000, 16'h0000, 0, 2'b11, 2'b00, 16'h63, 16'h0, 0, 3'd2, 3'd6, 16'h0005, 16'h0001, 16'h0000, 3'd2, 1);
        // Single-cycle result frozen under mem_stall, then released exactly once.
        issue(2'b00, 16'h0040, 16'h0002, 16'h0000, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd5, 3'd6, 16'h0042, 16'h0002, 16'h0000, 3'd5, 1);
        bus.mem_stall = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("stalled alu_result", bus.alu_result, 16'h0042);
            check("stalled valid_out", bus.valid_out, 1);
            check("stalled stall_out", bus.stall_out, 1);
        end
        bus.mem_stall = 1'b0;
`ifdef EX_MUL_EN
        issue(2'b10, 16'd3, 16'd5, 16'h0006, 16'h0020, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 3'd0, 3'd6, 16'h000F, 16'h0005, 16'h002C, 3'd6, 1);
        mulRun(16, -10);
        issue(2'b10, 16'h0100, 16'h0100, 16'h0006, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd1, 3'd6, 16'h0000, 16'h0100, 16'h000C, 3'd1, 1);
        mulRun(16, -10);
        issue(2'b10, 16'd7, 16'd9, 16'h0006, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd3, 3'd6, 16'h003F, 16'h0009, 16'h000C, 3'd3, 1);
        mulRun(19, 4);
`else
        issue(2'b10, 16'd3, 16'd5, 16'h0006, 16'h0020, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 3'd0, 3'd6, 16'h0008, 16'h0005, 16'h002C, 3'd6, 1);
        check("funct110 no stall", bus.stall_out, 0);
        check("funct110 latency", bus.valid_out, 1);
        issue(2'b10, 16'h0100, 16'h0100, 16'h0006, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd1, 3'd6, 16'h0200, 16'h0100, 16'h000C, 3'd1, 1);
`endif
        issue(2'b00, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0, 2'b00, 2'b00, 16'h0, 16'h0, 0, 3'd7, 3'd6, 16'h0002, 16'h0001, 16'h0000, 3'd7, 1);
        repeat (3) @(posedge clock);
        #1;
        check("queue drained", expQ.size(), 0);
        check("idle valid_out", bus.valid_out, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
